prbs_stream_gen: RTL and testbench

PRBS_STREAM_GEN -- requirements
Module: prbs_stream_gen

---
 rtl/prbs_stream_gen.sv | 87 ++++++++
 tb/tb_prbs_stream_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/prbs_stream_gen.sv
// Fibonacci LFSR pseudo-random word source with a valid/ready output stream,
// a transfer counter and a sticky flag for all-zero state substitution.
module prbs_stream_gen #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] SEED  = 24'h123456,
  parameter logic [WIDTH-1:0] POLY  = 24'h010100,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_count,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] tapped;
  logic             feedback;
  logic [WIDTH-1:0] shifted;
  logic             transfer;
  logic             shifted_zero;
  logic             seed_zero;

  assign tapped       = state_q & POLY;
  assign feedback     = ^tapped;
  assign shifted      = {state_q[WIDTH-2:0], feedback};
  assign shifted_zero = (shifted == '0);
  assign seed_zero    = (load_seed == '0);

  // A load blocks the handshake entirely, so a colliding transfer is dropped.
  assign transfer = valid_q & out_ready & ~load;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    count_d  = count_q;
    lockup_d = lockup_q;

    if (load) begin
      state_d  = seed_zero ? SEED : load_seed;
      valid_d  = 1'b0;
      count_d  = '0;
      lockup_d = seed_zero;
    end else begin
      valid_d = (valid_q & ~out_ready) | en;
      if (transfer) begin
        count_d = count_q + 1'b1;
        // The all-zero state would stick forever; reseed and flag it.
        if (shifted_zero) begin
          state_d  = SEED;
          lockup_d = 1'b1;
        end else begin
          state_d = shifted;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEED;
      valid_q  <= 1'b0;
      count_q  <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = state_q;
  assign word_count = count_q;
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Directed bench for prbs_stream_gen: streaming, backpressure, seed loads,
// lock-up recovery, load/transfer collision, async reset and counter wrap.
module tb_prbs_stream_gen;

  localparam int WIDTH = 24;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_seed;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] word_count;
  logic             lockup;

  // Narrow-counter instance sharing the stimulus, used for the wrap check.
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out_data;
  logic [1:0]       s_word_count;
  logic             s_lockup;

  int n_checks;
  int n_errors;

  prbs_stream_gen u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_seed (load_seed),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .word_count(word_count),
    .lockup    (lockup)
  );

  prbs_stream_gen #(.CNT_W(2)) u_small (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_seed (load_seed),
    .out_ready (out_ready),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .word_count(s_word_count),
    .lockup    (s_lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] seq [0:3];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    seq[0] = 24'h123456;
    seq[1] = 24'h2468AC;
    seq[2] = 24'h48D158;
    seq[3] = 24'h91A2B1;

    reset     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    load_seed = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    check_eq("rst_valid",  64'(out_valid),  64'd0);
    check_eq("rst_data",   64'(out_data),   64'h123456);
    check_eq("rst_count",  64'(word_count), 64'd0);
    check_eq("rst_lockup", 64'(lockup),     64'd0);

    // Reset-then-stream
    reset     = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("first_valid", 64'(out_valid),  64'd1);
    check_eq("first_count", 64'(word_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("stream_data%0d", i), 64'(out_data), 64'(seq[i]));
      tick();
      check_eq($sformatf("stream_count%0d", i), 64'(word_count), 64'(i + 1));
      check_eq($sformatf("wrap_count%0d", i), 64'(s_word_count), 64'((i + 1) % 4));
    end
    check_eq("stream_data4", 64'(out_data), 64'h234563);

    // Backpressure with en toggling
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = i[0];
      tick();
      check_eq($sformatf("bp_data%0d", i),  64'(out_data),   64'h234563);
      check_eq($sformatf("bp_valid%0d", i), 64'(out_valid),  64'd1);
      check_eq($sformatf("bp_count%0d", i), 64'(word_count), 64'd4);
    end
    out_ready = 1'b1;
    en        = 1'b0;
    tick();
    check_eq("bp_release_count", 64'(word_count), 64'd5);
    check_eq("bp_release_data",  64'(out_data),   64'h468AC6);
    check_eq("bp_release_valid", 64'(out_valid),  64'd0);
    tick();
    check_eq("idle_count", 64'(word_count), 64'd5);

    // Zero-seed load
    out_ready = 1'b0;
    load      = 1'b1;
    load_seed = 24'h000000;
    tick();
    check_eq("zload_data",   64'(out_data),   64'h123456);
    check_eq("zload_lockup", 64'(lockup),     64'd1);
    check_eq("zload_valid",  64'(out_valid),  64'd0);
    check_eq("zload_count",  64'(word_count), 64'd0);
    load_seed = 24'h000001;
    tick();
    check_eq("nzload_lockup", 64'(lockup),   64'd0);
    check_eq("nzload_data",   64'(out_data), 64'h000001);

    // Lock-up recovery
    load_seed = 24'h800000;
    tick();
    load      = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("lk_pre_data",  64'(out_data),  64'h800000);
    check_eq("lk_pre_valid", 64'(out_valid), 64'd1);
    tick();
    check_eq("lk_data",   64'(out_data),   64'h123456);
    check_eq("lk_lockup", 64'(lockup),     64'd1);
    check_eq("lk_count",  64'(word_count), 64'd1);
    tick();
    check_eq("lk_sticky", 64'(lockup),     64'd1);
    check_eq("lk_data2",  64'(out_data),   64'h2468AC);
    check_eq("lk_count2", 64'(word_count), 64'd2);

    // Load colliding with a transfer
    load      = 1'b1;
    load_seed = 24'hABCDEF;
    tick();
    check_eq("col_data",   64'(out_data),   64'hABCDEF);
    check_eq("col_count",  64'(word_count), 64'd0);
    check_eq("col_valid",  64'(out_valid),  64'd0);
    check_eq("col_lockup", 64'(lockup),     64'd0);
    load = 1'b0;

    // Async reset during a stall
    en        = 1'b1;
    out_ready = 1'b0;
    tick();
    en = 1'b0;
    tick();
    check_eq("stall_valid", 64'(out_valid), 64'd1);
    check_eq("stall_data",  64'(out_data),  64'hABCDEF);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid),  64'd0);
    check_eq("arst_data",  64'(out_data),   64'h123456);
    check_eq("arst_count", 64'(word_count), 64'd0);
    #2;
    reset = 1'b1;
    tick();
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
